// File: rtl/conv_pixel_packer.sv
// Converts convolution results into saturated 8-bit pixels, packs four per 32-bit word,
// and writes packed words to frame memory through a small FIFO with an ack handshake.
module conv_pixel_packer #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [8:0] LAST_H     = 9'h1ff,
  parameter logic [8:0] LAST_V     = 9'h1df
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_result,
  input  logic        in_mode,
  input  logic [8:0]  in_h,
  input  logic [8:0]  in_v,
  input  logic        in_flush,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic        frame_done,
  output logic        busy
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  function automatic logic [16:0] abs17(input logic signed [15:0] x);
    logic [16:0] xe;
    xe = {x[15], x};
    return x[15] ? (~xe + 17'd1) : xe;
  endfunction

  function automatic logic [7:0] sat8(input logic [17:0] s);
    return (s > 18'd255) ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [31:0] keep_lanes(input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = m[k] ? d[8*k +: 8] : 8'h00;
    return r;
  endfunction

  state_t             state_q;
  logic               frame_done_q;
  logic [CW-1:0]      count_q, count_d;
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic               open_q, open_d;
  logic [3:0]         mask_q, mask_d;
  logic [15:0]        idx_q, idx_d;
  logic [31:0]        data_q, data_d;
  logic [15:0]        fifo_addr_q [FIFO_DEPTH];
  logic [31:0]        fifo_data_q [FIFO_DEPTH];

  logic signed [15:0] res_a, res_b;
  logic [17:0]        pix_sum;
  logic [7:0]         pixel;
  logic [15:0]        new_idx;
  logic               accept, pop, last_px;
  logic [1:0]         push_n;
  logic [15:0]        push_addr0, push_addr1;
  logic [31:0]        push_data0, push_data1;

  // Stage p0: combinational magnitude / saturation ahead of the packer register
  assign res_a   = signed'(in_result[15:0]);
  assign res_b   = signed'(in_result[31:16]);
  assign pix_sum = in_mode ? ({1'b0, abs17(res_a)} + {1'b0, abs17(res_b)})
                           : {1'b0, abs17(res_a)};
  assign pixel   = sat8(pix_sum);

  assign new_idx  = {in_v, in_h[8:2]};
  assign in_ready = (count_q <= CW'(FIFO_DEPTH - 2)) && (state_q == RUN);
  assign accept   = in_valid && in_ready;
  assign last_px  = (in_h == LAST_H) && (in_v == LAST_V);
  assign pop      = mem_we && mem_ack;

  // Up to two pushes per cycle: index-change eviction first, then completion or flush.
  always_comb begin
    idx_d      = idx_q;
    data_d     = data_q;
    mask_d     = mask_q;
    open_d     = open_q;
    push_n     = 2'd0;
    push_addr0 = '0;
    push_data0 = '0;
    push_addr1 = '0;
    push_data1 = '0;
    if (accept) begin
      if (open_q && (new_idx != idx_q)) begin
        push_addr0 = idx_q;
        push_data0 = keep_lanes(data_q, mask_q);
        push_n     = 2'd1;
        open_d     = 1'b0;
      end
      if (!open_d) begin
        idx_d  = new_idx;
        mask_d = 4'b0000;
      end
      data_d[{in_h[1:0], 3'b000} +: 8] = pixel;
      mask_d[in_h[1:0]] = 1'b1;
      open_d = 1'b1;
      if ((in_h[1:0] == 2'd3) || (in_h == LAST_H)) begin
        if (push_n == 2'd0) begin
          push_addr0 = idx_d;
          push_data0 = keep_lanes(data_d, mask_d);
        end else begin
          push_addr1 = idx_d;
          push_data1 = keep_lanes(data_d, mask_d);
        end
        push_n = push_n + 2'd1;
        open_d = 1'b0;
        mask_d = 4'b0000;
      end
    end
    // A stand-alone flush with a full FIFO waits until a slot frees up.
    if (in_flush && open_d && ((count_q + CW'(push_n)) < CW'(FIFO_DEPTH))) begin
      if (push_n == 2'd0) begin
        push_addr0 = idx_d;
        push_data0 = keep_lanes(data_d, mask_d);
      end else begin
        push_addr1 = idx_d;
        push_data1 = keep_lanes(data_d, mask_d);
      end
      push_n = push_n + 2'd1;
      open_d = 1'b0;
      mask_d = 4'b0000;
    end
    count_d = count_q + CW'(push_n) - CW'(pop);
  end

  // Stage p1: packer and FIFO storage (data only, no reset)
  always_ff @(posedge clk) begin
    idx_q  <= idx_d;
    data_q <= data_d;
    if (push_n != 2'd0) begin
      fifo_addr_q[wr_ptr_q] <= push_addr0;
      fifo_data_q[wr_ptr_q] <= push_data0;
    end
    if (push_n == 2'd2) begin
      fifo_addr_q[wr_ptr_q + PW'(1)] <= push_addr1;
      fifo_data_q[wr_ptr_q + PW'(1)] <= push_data1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      open_q   <= 1'b0;
      mask_q   <= 4'b0000;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_q + PW'(push_n);
      rd_ptr_q <= rd_ptr_q + PW'(pop);
      open_q   <= open_d;
      mask_q   <= mask_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RUN;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        RUN:   if (accept && last_px) state_q <= DRAIN;
        DRAIN: if (count_d == '0) begin
                 state_q      <= DONE;
                 frame_done_q <= 1'b1;
               end
        DONE:  state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  assign mem_we     = (count_q != '0);
  assign mem_addr   = mem_we ? fifo_addr_q[rd_ptr_q] : 16'h0000;
  assign mem_wdata  = mem_we ? fifo_data_q[rd_ptr_q] : 32'h0000_0000;
  assign frame_done = frame_done_q;
  assign busy       = open_q || mem_we || (state_q != RUN);

endmodule

// File: tb/tb_conv_pixel_packer.sv
// Scoreboard bench for conv_pixel_packer: expected memory writes are queued as pixels are
// driven and compared as the DUT retires them through the mem_we/mem_ack handshake.
module tb_conv_pixel_packer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_result = '0;
  logic        in_mode = 1'b0;
  logic [8:0]  in_h = '0;
  logic [8:0]  in_v = '0;
  logic        in_flush = 1'b0;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic        frame_done;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  always #5 clk = ~clk;

  conv_pixel_packer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_mode    (in_mode),
    .in_h       (in_h),
    .in_v       (in_v),
    .in_flush   (in_flush),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .frame_done (frame_done),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic [15:0] a, input logic [31:0] d);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
  endtask

  // Drive at posedge+1, wait for in_ready (sampled at negedge), return after the accept edge.
  task automatic send(input int h, input int v, input int m, input int a, input int b);
    int n;
    n = 0;
    in_valid  = 1'b1;
    in_h      = 9'(h);
    in_v      = 9'(v);
    in_mode   = 1'(m);
    in_result = {16'(b), 16'(a)};
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic flush();
    in_flush = 1'b1;
    @(posedge clk);
    #1;
    in_flush = 1'b0;
  endtask

  // Write monitor: retire expected writes, and check head stability while stalled.
  initial begin
    logic        stall_seen;
    logic [15:0] stall_addr;
    logic [31:0] stall_data;
    stall_seen = 1'b0;
    stall_addr = '0;
    stall_data = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stall_seen = 1'b0;
      end else begin
        if (stall_seen) begin
          chk("stall_we", 32'(mem_we), 32'd1);
          chk("stall_addr", 32'(mem_addr), 32'(stall_addr));
          chk("stall_data", mem_wdata, stall_data);
        end
        if (mem_we && mem_ack) begin
          chk("write_expected", 32'(exp_addr_q.size() != 0), 32'd1);
          if (exp_addr_q.size() != 0) begin
            chk("wr_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
            chk("wr_data", mem_wdata, exp_data_q.pop_front());
          end
        end
        stall_seen = mem_we && !mem_ack;
        stall_addr = mem_addr;
        stall_data = mem_wdata;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses, pop_cyc, fd_cyc;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_data", mem_wdata, 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mem_ack = 1'b1;
    cycles(2);

    // Raster fill of one word
    expect_wr(16'h0000, 32'h0403_0201);
    for (int h = 0; h < 4; h++) send(h, 0, 0, h + 1, 0);
    idle();
    @(negedge clk);
    chk("raster_we_on", 32'(mem_we), 32'd1);
    @(negedge clk);
    chk("raster_we_off", 32'(mem_we), 32'd0);
    cycles(2);

    // Saturation / absolute value, flushed partial words
    expect_wr(16'h0200, 32'h0000_00FF);
    send(0, 4, 0, -300, 0);
    idle();
    chk("sat_busy_open", 32'(busy), 32'd1);
    flush();
    expect_wr(16'h0280, 32'h0000_005A);
    send(0, 5, 1, 40, -50);
    idle();
    flush();
    expect_wr(16'h0300, 32'h0000_00FF);
    send(0, 6, 1, -32768, 0);
    idle();
    flush();
    expect_wr(16'h0380, 32'h0000_C800);
    send(1, 7, 1, 100, 100);
    idle();
    flush();
    cycles(3);

    // Index-change eviction
    expect_wr(16'h0081, 32'h0000_2211);
    send(4, 1, 0, 'h11, 0);
    send(5, 1, 0, 'h22, 0);
    send(12, 1, 0, 'h33, 0);
    idle();
    cycles(3);
    chk("idx_open_busy", 32'(busy), 32'd1);
    chk("idx_fifo_empty", 32'(mem_we), 32'd0);
    expect_wr(16'h0083, 32'h0000_0033);
    flush();
    cycles(3);
    chk("idx_idle", 32'(busy), 32'd0);

    // Backpressure
    mem_ack = 1'b0;
    expect_wr(16'h0100, 32'h0403_0201);
    expect_wr(16'h0101, 32'h0807_0605);
    expect_wr(16'h0102, 32'h0C0B_0A09);
    for (int h = 0; h < 12; h++) begin
      send(h, 2, 0, h + 1, 0);
      if (h == 3) chk("bp_ready_cnt1", 32'(in_ready), 32'd1);
      if (h == 7) chk("bp_ready_cnt2", 32'(in_ready), 32'd1);
      if (h == 11) chk("bp_ready_cnt3", 32'(in_ready), 32'd0);
    end
    idle();
    cycles(4);
    chk("bp_still_stalled", 32'(in_ready), 32'd0);
    mem_ack = 1'b1;
    cycles(6);
    chk("bp_drained", 32'(exp_addr_q.size()), 32'd0);
    chk("bp_ready_back", 32'(in_ready), 32'd1);

    // Row end / frame end with delayed ack
    mem_ack = 1'b0;
    expect_wr(16'hEFFF, 32'h7F7F_7F7F);
    for (int h = 508; h < 512; h++) send(h, 479, 0, 'h7F, 0);
    idle();
    chk("drain_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("drain_ready", 32'(in_ready), 32'd0);
      cycles(1);
    end
    mem_ack = 1'b1;
    pulses  = 0;
    pop_cyc = -10;
    fd_cyc  = -20;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_we && mem_ack) pop_cyc = i;
      if (frame_done) begin
        pulses++;
        fd_cyc = i;
      end
    end
    chk("fd_pulses", 32'(pulses), 32'd1);
    chk("fd_after_pop", 32'(fd_cyc - pop_cyc), 32'd1);
    chk("fd_busy_after", 32'(busy), 32'd0);
    chk("fd_ready_after", 32'(in_ready), 32'd1);
    chk("fd_low_after", 32'(frame_done), 32'd0);

    // Reset mid-operation: two FIFO entries plus an open packer
    mem_ack = 1'b0;
    for (int h = 0; h < 9; h++) send(h, 3, 0, 'h55, 0);
    idle();
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_we", 32'(mem_we), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_we", 32'(mem_we), 32'd0);
    chk("async_addr", 32'(mem_addr), 32'd0);
    chk("async_ready", 32'(in_ready), 32'd1);
    chk("async_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    mem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_no_write", 32'(mem_we), 32'd0);
    end
    chk("post_rst_busy", 32'(busy), 32'd0);

    chk("queue_empty", 32'(exp_addr_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
